// File: rtl/rp_8bit_io_timer_pkg.sv
// rp_8bit_io_pkg: shared definitions for the rp_8bit I/O timer.
//   - register offsets inside the 8-address window
//   - clock-select (CS) encoding
//   - TCR / TIFR / TIMSK bit indices
//   - prescaler helpers: running check and divisor-1 lookup
package rp_8bit_io_pkg;

  localparam logic [2:0] OFF_TCR   = 3'd0;
  localparam logic [2:0] OFF_TCNT  = 3'd1;
  localparam logic [2:0] OFF_OCR   = 3'd2;
  localparam logic [2:0] OFF_TIFR  = 3'd3;
  localparam logic [2:0] OFF_TIMSK = 3'd4;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_DIV1    = 3'd1,
    CS_DIV8    = 3'd2,
    CS_DIV64   = 3'd3,
    CS_DIV256  = 3'd4,
    CS_DIV1024 = 3'd5,
    CS_RSV6    = 3'd6,
    CS_RSV7    = 3'd7
  } cs_e;

  localparam int TCR_CS_LSB = 0;
  localparam int TCR_CTC    = 3;
  localparam int TIFR_TOV   = 0;
  localparam int TIFR_OCF   = 1;
  localparam int TIMSK_TOIE = 0;
  localparam int TIMSK_OCIE = 1;

  // Codes 0, 6 and 7 all mean "stopped".
  function automatic logic cs_running(cs_e cs);
    case (cs)
      CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // Terminal count of the prescaler (divisor - 1).
  function automatic logic [9:0] cs_div_m1(cs_e cs);
    case (cs)
      CS_DIV8:    return 10'd7;
      CS_DIV64:   return 10'd63;
      CS_DIV256:  return 10'd255;
      CS_DIV1024: return 10'd1023;
      default:    return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/rp_8bit_io_timer_if.sv
// rp_8bit_io_timer_if: rp_8bit I/O peripheral bus.
//   io_wen/io_ren  write / read strobes (initiator -> responder)
//   io_adr[5:0]    I/O address
//   io_wdt[7:0]    write data, io_msk[7:0] per-bit write mask
//   io_rdt[7:0]    registered read data (responder -> initiator)
// master = core (initiator), slave = peripheral (responder).
interface rp_8bit_io_timer_if;
  logic       io_wen;
  logic       io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt;
  logic [7:0] io_msk;
  logic [7:0] io_rdt;

  modport master (output io_wen, io_ren, io_adr, io_wdt, io_msk, input  io_rdt);
  modport slave  (input  io_wen, io_ren, io_adr, io_wdt, io_msk, output io_rdt);
endinterface

// File: rtl/rp_8bit_io_timer_prescaler.sv
// rp_8bit_io_prescaler: 10-bit divider producing a one-cycle tick.
//   clk, rst  clock, async active-low reset
//   cs        clock-select code (stopped codes hold the divider at 0)
//   clear     restart the divider from 0 next cycle
//   tick      combinational, high in the cycle the count sits at divisor-1
module rp_8bit_io_prescaler
  import rp_8bit_io_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  cs_e  cs,
  input  logic clear,
  output logic tick
);

  logic [9:0] cnt_q, cnt_d;
  logic       run;

  always_comb begin
    run   = cs_running(cs);
    tick  = run && (cnt_q == cs_div_m1(cs));
    cnt_d = cnt_q + 10'd1;
    if (clear || !run || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rp_8bit_io_timer.sv
// rp_8bit_io_timer: 8-bit timer/counter on the rp_8bit I/O bus.
//   clk, rst        clock, async active-low reset
//   io (slave)      bus responder, window BAS..BAS+7
//   irq_req[1:0]    [0] overflow, [1] compare match (TIFR & TIMSK)
//   irq_ack[1:0]    one-cycle acknowledge, clears the matching flag
//   pwm             only with RP_8BIT_IO_TIMER_PWM_EN: registered TCNT < OCR
// Map: +0 TCR {CTC,CS[2:0]}, +1 TCNT, +2 OCR, +3 TIFR {OCF,TOV} (W1C),
//      +4 TIMSK {OCIE,TOIE}, +5..+7 read 0 / write ignored.
module rp_8bit_io_timer
  import rp_8bit_io_pkg::*;
#(
  parameter logic [5:0] BAS = 6'h20,
  parameter int         IRB = 0
)(
  input  logic                clk,
  input  logic                rst,
  rp_8bit_io_timer_if.slave   io,
  output logic [1:0]          irq_req,
  input  logic [1:0]          irq_ack
`ifdef RP_8BIT_IO_TIMER_PWM_EN
  ,output logic               pwm
`endif
);

  // IRB only matters for wiring at the top level.
  logic unused_irb;
  assign unused_irb = (IRB != 0);

  logic [3:0] tcr_q, tcr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [7:0] ocr_q, ocr_d;
  logic [1:0] tifr_q, tifr_d;
  logic [1:0] timsk_q, timsk_d;
  logic [7:0] rdt_q, rdt_d;

  logic       in_win, wr_tcr, wr_tcnt, wr_ocr, wr_tifr, wr_timsk;
  logic [2:0] off;
  logic [3:0] tcr_new;
  logic       cmp, ovf, presc_clr, tick;
  logic [1:0] flag_set, flag_clr;
  cs_e        cs_q;

  assign cs_q    = cs_e'(tcr_q[TCR_CS_LSB +: 3]);
  assign irq_req = tifr_q & timsk_q;

  rp_8bit_io_prescaler u_presc (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs_q),
    .clear (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    in_win   = (io.io_adr[5:3] == BAS[5:3]);
    off      = io.io_adr[2:0];
    wr_tcr   = io.io_wen && in_win && (off == OFF_TCR);
    wr_tcnt  = io.io_wen && in_win && (off == OFF_TCNT);
    wr_ocr   = io.io_wen && in_win && (off == OFF_OCR);
    wr_tifr  = io.io_wen && in_win && (off == OFF_TIFR);
    wr_timsk = io.io_wen && in_win && (off == OFF_TIMSK);

    tcr_new = (io.io_wdt[3:0] & io.io_msk[3:0]) | (tcr_q & ~io.io_msk[3:0]);
    tcr_d   = wr_tcr ? tcr_new : tcr_q;
    // Restart the divider while stopped and whenever CS actually changes.
    presc_clr = !cs_running(cs_q) || (wr_tcr && (tcr_new[2:0] != tcr_q[2:0]));

    // Compare against the current OCR, so a same-cycle OCR write is not seen.
    cmp = (tcnt_q == ocr_q);
    ovf = (tcnt_q == 8'hFF);

    tcnt_d = tcnt_q;
    if (wr_tcnt)
      tcnt_d = (io.io_wdt & io.io_msk) | (tcnt_q & ~io.io_msk);
    else if (tick)
      tcnt_d = (tcr_q[TCR_CTC] && cmp) ? 8'h00 : tcnt_q + 8'd1;

    ocr_d = wr_ocr ? ((io.io_wdt & io.io_msk) | (ocr_q & ~io.io_msk)) : ocr_q;

    // A CPU write to TCNT swallows the coincident tick, flags included.
    flag_set = '0;
    if (tick && !wr_tcnt) begin
      flag_set[TIFR_TOV] = ovf;
      flag_set[TIFR_OCF] = cmp;
    end
    flag_clr = (irq_ack & irq_req);
    if (wr_tifr) flag_clr = flag_clr | (io.io_wdt[1:0] & io.io_msk[1:0]);
    // Set after clear: a new event is never lost to a clear or ack.
    tifr_d = (tifr_q & ~flag_clr) | flag_set;

    timsk_d = wr_timsk ? ((io.io_wdt[1:0] & io.io_msk[1:0]) | (timsk_q & ~io.io_msk[1:0]))
                       : timsk_q;

    // Out-of-window reads return 0 so responders can be OR-combined.
    rdt_d = rdt_q;
    if (io.io_ren) begin
      rdt_d = 8'h00;
      if (in_win) begin
        case (off)
          OFF_TCR:   rdt_d = {4'h0, tcr_q};
          OFF_TCNT:  rdt_d = tcnt_q;
          OFF_OCR:   rdt_d = ocr_q;
          OFF_TIFR:  rdt_d = {6'h00, tifr_q};
          OFF_TIMSK: rdt_d = {6'h00, timsk_q};
          default:   rdt_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcr_q   <= '0;
      tcnt_q  <= '0;
      ocr_q   <= '0;
      tifr_q  <= '0;
      timsk_q <= '0;
      rdt_q   <= '0;
    end else begin
      tcr_q   <= tcr_d;
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
      rdt_q   <= rdt_d;
    end
  end

  assign io.io_rdt = rdt_q;

`ifdef RP_8BIT_IO_TIMER_PWM_EN
  logic pwm_q, pwm_d;

  always_comb pwm_d = cs_running(cs_q) && (tcnt_q < ocr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_q <= 1'b0;
    else      pwm_q <= pwm_d;
  end

  assign pwm = pwm_q;
`endif

endmodule

// File: tb/tb_rp_8bit_io_timer.sv
// Directed bench for rp_8bit_io_timer. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_rp_8bit_io_timer;

  localparam logic [5:0] BAS = 6'h20;
  localparam logic [5:0] A_TCR   = BAS + 6'd0;
  localparam logic [5:0] A_TCNT  = BAS + 6'd1;
  localparam logic [5:0] A_OCR   = BAS + 6'd2;
  localparam logic [5:0] A_TIFR  = BAS + 6'd3;
  localparam logic [5:0] A_TIMSK = BAS + 6'd4;

  logic       clk, rst;
  logic [1:0] irq_req, irq_ack;
`ifdef RP_8BIT_IO_TIMER_PWM_EN
  logic       pwm;
`endif

  int nvec = 0;
  int nerr = 0;

  rp_8bit_io_timer_if bus ();

  rp_8bit_io_timer #(.BAS(BAS), .IRB(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (bus),
    .irq_req (irq_req),
    .irq_ack (irq_ack)
`ifdef RP_8BIT_IO_TIMER_PWM_EN
    ,.pwm    (pwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called and returning on a falling edge; the write lands on the rising edge between.
  task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
    bus.io_wen = 1'b1; bus.io_adr = a; bus.io_wdt = d; bus.io_msk = m;
    @(negedge clk);
    bus.io_wen = 1'b0; bus.io_msk = 8'h00;
  endtask

  task automatic rchk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    bus.io_ren = 1'b1; bus.io_adr = a;
    @(negedge clk);
    bus.io_ren = 1'b0;
    chk(tag, bus.io_rdt, exp);
  endtask

`ifdef RP_8BIT_IO_TIMER_PWM_EN
  task automatic pwm_count(input logic [7:0] ocr, input logic [7:0] exp_hi);
    int pc;
    wr(A_TCR, 8'h00, 8'hFF);
    wr(A_TCNT, 8'h00, 8'hFF);
    wr(A_OCR, ocr, 8'hFF);
    wr(A_TCR, 8'h01, 8'hFF);
    pc = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      pc += int'(pwm);
    end
    chk("pwm_duty", 8'(pc), exp_hi);
    wr(A_TCR, 8'h00, 8'hFF);
    @(negedge clk);
    chk("pwm_stop", {7'h0, pwm}, 8'h00);
  endtask
`endif

  initial begin
    rst = 1'b0;
    irq_ack = 2'b00;
    bus.io_wen = 1'b0; bus.io_ren = 1'b0; bus.io_adr = '0;
    bus.io_wdt = '0;   bus.io_msk = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdt", bus.io_rdt, 8'h00);
    chk("rst_irq", {6'h0, irq_req}, 8'h00);
    rst = 1'b1;

    // Reset values across the window and just outside it.
    for (int i = 0; i < 8; i++) rchk("rd_rst", 6'(BAS + 6'(i)), 8'h00);
    rchk("rd_oow_hi", 6'h28, 8'h00);

    // Read hold and out-of-window zero.
    wr(A_TCNT, 8'h55, 8'hFF);
    rchk("tcnt_55", A_TCNT, 8'h55);
    repeat (2) @(negedge clk);
    chk("rdt_hold", bus.io_rdt, 8'h55);
    rchk("rd_oow_lo", 6'h01, 8'h00);
    wr(A_TCNT, 8'h00, 8'hFF);

    // Masked writes, unused bits, ignored offsets.
    wr(A_TCR, 8'hFF, 8'h03);
    rchk("tcr_mask", A_TCR, 8'h03);
    wr(A_TCR, 8'h00, 8'hFF);
    rchk("tcnt_idle", A_TCNT, 8'h00);
    wr(A_TCR, 8'hFF, 8'hFF);
    rchk("tcr_hi0", A_TCR, 8'h0F);
    wr(A_TCR, 8'h00, 8'hFF);
    wr(6'h25, 8'hFF, 8'hFF);
    rchk("off5", 6'h25, 8'h00);
    wr(A_OCR, 8'hA5, 8'hFF);
    wr(A_OCR, 8'h0F, 8'hF0);
    rchk("ocr_merge", A_OCR, 8'h05);

    // CS=1 overflow: FE, FF, 00 on consecutive reads; TOV visible after wrap.
    wr(A_TCNT, 8'hFE, 8'hFF);
    wr(A_TIMSK, 8'h01, 8'hFF);
    wr(A_TCR, 8'h01, 8'hFF);
    bus.io_ren = 1'b1; bus.io_adr = A_TCNT;
    @(negedge clk);
    chk("ovf_fe", bus.io_rdt, 8'hFE);
    chk("ovf_irq0", {6'h0, irq_req}, 8'h00);
    @(negedge clk);
    chk("ovf_ff", bus.io_rdt, 8'hFF);
    chk("ovf_irq1", {6'h0, irq_req}, 8'h01);
    @(negedge clk);
    chk("ovf_00", bus.io_rdt, 8'h00);
    chk("ovf_irq2", {6'h0, irq_req}, 8'h01);
    bus.io_ren = 1'b0;
    irq_ack = 2'b01;
    @(negedge clk);
    irq_ack = 2'b00;
    chk("ack_clr", {6'h0, irq_req}, 8'h00);
    wr(A_TCR, 8'h00, 8'hFF);

    // CTC with OCR=5: 0..5 repeating, OCF on each 5->0, never TOV.
    wr(A_TIFR, 8'hFF, 8'hFF);
    wr(A_TCNT, 8'h00, 8'hFF);
    wr(A_TIMSK, 8'h03, 8'hFF);
    wr(A_TCR, 8'h09, 8'hFF);
    bus.io_ren = 1'b1; bus.io_adr = A_TCNT;
    for (int k = 1; k <= 13; k++) begin
      logic [7:0] e;
      @(negedge clk);
      irq_ack = 2'b00;
      e = 8'((k - 1) % 6);
      chk("ctc_tcnt", bus.io_rdt, e);
      chk("ctc_irq", {6'h0, irq_req}, (e == 8'h05) ? 8'h02 : 8'h00);
      if (e == 8'h05) irq_ack = 2'b10;
    end
    bus.io_ren = 1'b0;
    irq_ack = 2'b00;
    wr(A_TCR, 8'h00, 8'hFF);

    // CS=2: one increment per 8 clocks; TCNT write beats a coincident tick.
    wr(A_TIFR, 8'hFF, 8'hFF);
    wr(A_TIMSK, 8'h00, 8'hFF);
    wr(A_TCNT, 8'h00, 8'hFF);
    wr(A_TCR, 8'h02, 8'hFF);
    bus.io_ren = 1'b1; bus.io_adr = A_TCNT;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("div8", bus.io_rdt, 8'((k - 1) / 8));
    end
    bus.io_ren = 1'b0;
    repeat (7) @(negedge clk);
    wr(A_TCNT, 8'h10, 8'hFF);            // lands on the third tick
    rchk("wr_beats_tick", A_TCNT, 8'h10);
    wr(A_TCR, 8'h00, 8'hFF);
    rchk("no_flag_on_wr", A_TIFR, 8'h00);

    // Pending TOV, ack with irq_req low, W1C racing a new overflow.
    wr(A_TCNT, 8'hFF, 8'hFF);
    wr(A_TCR, 8'h01, 8'hFF);
    wr(A_TCR, 8'h00, 8'hFF);             // single tick: FF -> 00, TOV
    rchk("tov_pend", A_TIFR, 8'h01);
    rchk("tov_wrap", A_TCNT, 8'h00);
    irq_ack = 2'b01;
    @(negedge clk);
    irq_ack = 2'b00;
    rchk("ack_masked", A_TIFR, 8'h01);
    wr(A_TCNT, 8'hFF, 8'hFF);
    wr(A_TCR, 8'h01, 8'hFF);
    wr(A_TIFR, 8'h01, 8'h01);            // W1C on the overflow tick
    wr(A_TCR, 8'h00, 8'hFF);
    rchk("set_wins", A_TIFR, 8'h01);
    rchk("after_race", A_TCNT, 8'h01);
    wr(A_TIFR, 8'h01, 8'h01);
    rchk("w1c", A_TIFR, 8'h00);

    // Asynchronous reset in the middle of a count.
    wr(A_TCNT, 8'hFE, 8'hFF);
    wr(A_TIMSK, 8'h01, 8'hFF);
    wr(A_TCR, 8'h01, 8'hFF);
    repeat (3) @(negedge clk);
    rchk("pre_rst_tcnt", A_TCNT, 8'h01);
    chk("pre_rst_irq", {6'h0, irq_req}, 8'h01);
    #2 rst = 1'b0;
    #1;
    chk("async_rdt", bus.io_rdt, 8'h00);
    chk("async_irq", {6'h0, irq_req}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rchk("post_rst_tcnt", A_TCNT, 8'h00);
    rchk("post_rst_tcr", A_TCR, 8'h00);

`ifdef RP_8BIT_IO_TIMER_PWM_EN
    pwm_count(8'h40, 8'd64);
    pwm_count(8'h00, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
